wm_text_reader: RTL and testbench

- Read-side counterpart to the matcher's loadable storage. Fetches payload bytes from the text buffer memory and presents the Wu-Manber B-byte suffix window for each candidate alignment to the SHIFT/HASH lookup stage.
- Advances the alignment by the shift value returned from that stage.
- Sits between the packet text buffer (1-cycle synchronous read) and the matcher pipeline. Uses a valid/ready window handshake.

---
 rtl/wm_text_reader_pkg.sv | 30 +++
 rtl/wm_text_reader_if.sv | 35 +++
 rtl/wm_window_shifter.sv | 41 ++++
 rtl/wm_text_reader.sv | 112 +++++++++++
 tb/tb_wm_text_reader.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/wm_text_reader_pkg.sv
// ----------------------------------------------------------------------------
// wm_pkg
// Types and constants shared by the text reader and the matcher pipeline.
//   BYTE_WIDTH  : width of one text byte
//   DEFAULT_B   : default block (window) size in bytes
//   DEFAULT_M   : default minimum pattern length
//   wm_state_t  : reader FSM state encoding
//   shift_to_step : maps a SHIFT table value to the alignment advance
// ----------------------------------------------------------------------------
package wm_pkg;

   localparam int BYTE_WIDTH = 8;
   localparam int DEFAULT_B  = 2;
   localparam int DEFAULT_M  = 4;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LAST,
      VALID,
      DONE
   } wm_state_t;

   // A zero shift means "possible match here"; the scan must still make
   // progress, so it advances by one byte.
   function automatic int unsigned shift_to_step(input int unsigned shift);
      return (shift == 0) ? 1 : shift;
   endfunction

endpackage

// File: rtl/wm_text_reader_if.sv
// ----------------------------------------------------------------------------
// wm_text_reader_if
// Bundles the text buffer read port and the window handshake.
//   mem_rd_en / mem_addr / mem_rdata : text buffer, 1-cycle synchronous read
//   win_valid / win_ready            : window handshake
//   win_data / win_pos               : window bytes and index of last byte
//   win_shift                        : shift for the next alignment
// master = reader side, slave = memory + matcher side.
// ----------------------------------------------------------------------------
interface wm_text_reader_if #(
   parameter int ADDR_WIDTH  = 10,
   parameter int B           = 2,
   parameter int SHIFT_WIDTH = 4
);

   logic                   mem_rd_en;
   logic [ADDR_WIDTH-1:0]  mem_addr;
   logic [7:0]             mem_rdata;
   logic                   win_valid;
   logic                   win_ready;
   logic [8*B-1:0]         win_data;
   logic [ADDR_WIDTH-1:0]  win_pos;
   logic [SHIFT_WIDTH-1:0] win_shift;

   modport master (
      output mem_rd_en, mem_addr, win_valid, win_data, win_pos,
      input  mem_rdata, win_ready, win_shift
   );

   modport slave (
      input  mem_rd_en, mem_addr, win_valid, win_data, win_pos,
      output mem_rdata, win_ready, win_shift
   );

endinterface

// File: rtl/wm_window_shifter.sv
// ----------------------------------------------------------------------------
// wm_window_shifter
// B-byte shift register assembling the suffix window. New bytes enter at the
// low end, so after B loads in ascending address order dout[7:0] holds the
// highest-addressed byte.
//   clk, reset : clock, async active-high reset
//   clear      : synchronous clear to zero
//   load       : shift din in
//   din        : incoming byte
//   dout       : window contents
// ----------------------------------------------------------------------------
module wm_window_shifter
   import wm_pkg::*;
#(
   parameter int B = DEFAULT_B
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear,
   input  logic                    load,
   input  logic [BYTE_WIDTH-1:0]   din,
   output logic [BYTE_WIDTH*B-1:0] dout
);

   logic [BYTE_WIDTH*B-1:0] next_data;

   generate
      if (B == 1) begin : g_single
         assign next_data = din;
      end else begin : g_multi
         assign next_data = {dout[BYTE_WIDTH*(B-1)-1:0], din};
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset)      dout <= '0;
      else if (clear) dout <= '0;
      else if (load)  dout <= next_data;
   end

endmodule

// File: rtl/wm_text_reader.sv
// ----------------------------------------------------------------------------
// wm_text_reader
// Walks the Wu-Manber alignments over a text buffer. For each alignment it
// fetches the B bytes ending at pos, presents them as a window, and advances
// pos by the shift the matcher returns.
//   clk, reset : clock, async active-high reset
//   start, len : begin a scan of len bytes (accepted only in IDLE)
//   clear      : synchronous abort back to IDLE
//   busy, done : scan in progress / 1-cycle end-of-scan pulse
//   bus        : text buffer read port and window handshake (master)
// ----------------------------------------------------------------------------
module wm_text_reader
   import wm_pkg::*;
#(
   parameter int ADDR_WIDTH  = 10,
   parameter int B           = DEFAULT_B,
   parameter int M           = DEFAULT_M,
   parameter int SHIFT_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH:0]   len,
   input  logic                  clear,
   output logic                  busy,
   output logic                  done,
   wm_text_reader_if.master      bus
);

   localparam int PW = ADDR_WIDTH + 1;
   localparam int CW = (B > 1) ? $clog2(B) : 1;

   wm_state_t             state, next_state;
   logic [ADDR_WIDTH-1:0] pos;
   logic [PW-1:0]         len_q;
   logic [CW-1:0]         cnt;
   logic                  rd_en_q;
   logic                  last_issue;
   logic [PW-1:0]         next_pos;

   assign last_issue = (cnt == CW'(B - 1));

   // One extra bit so a large shift near the end of a full-length text
   // compares correctly against len instead of wrapping to a low address.
   assign next_pos = {1'b0, pos} + PW'(shift_to_step(32'(bus.win_shift)));

   always_ff @(posedge clk or posedge reset) begin
      if (reset)      state <= IDLE;
      else if (clear) state <= IDLE;
      else            state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = (len < PW'(M)) ? DONE : FETCH;
         FETCH:   if (last_issue) next_state = LAST;
         LAST:    next_state = VALID;
         VALID:   if (bus.win_ready) next_state = (next_pos >= len_q) ? DONE : FETCH;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // rd_en_q marks cycles where mem_rdata carries a byte requested on the
   // previous edge; it drives the window load one cycle behind the fetch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset || clear) begin
         pos     <= '0;
         len_q   <= '0;
         cnt     <= '0;
         rd_en_q <= 1'b0;
      end else begin
         rd_en_q <= (state == FETCH);
         case (state)
            IDLE: begin
               if (start) begin
                  len_q <= len;
                  pos   <= ADDR_WIDTH'(M - 1);
                  cnt   <= '0;
               end
            end
            FETCH: cnt <= last_issue ? '0 : cnt + 1'b1;
            VALID: begin
               if (bus.win_ready && (next_pos < len_q)) pos <= next_pos[ADDR_WIDTH-1:0];
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.mem_rd_en = (state == FETCH);
      bus.mem_addr  = '0;
      if (state == FETCH) bus.mem_addr = pos - ADDR_WIDTH'(B - 1) + ADDR_WIDTH'(cnt);
      bus.win_valid = (state == VALID);
      busy          = (state == FETCH) || (state == LAST) || (state == VALID);
      done          = (state == DONE);
   end

   assign bus.win_pos = pos;

   wm_window_shifter #(.B(B)) u_shifter (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .load  (rd_en_q),
      .din   (bus.mem_rdata),
      .dout  (bus.win_data)
   );

endmodule

// File: tb/tb_wm_text_reader.sv
// ----------------------------------------------------------------------------
// tb_wm_text_reader
// Self-checking bench for wm_text_reader: a table of known windows, randomized
// scans against a model of the alignment walk, and hand-written sequences for
// short text, backpressure, clear, async reset and full-length text.
// ----------------------------------------------------------------------------
module tb_wm_text_reader;
   import wm_pkg::*;

   localparam int AW = 10;
   localparam int B  = 2;
   localparam int M  = 4;
   localparam int SW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          clear;
   logic [AW:0]   len;
   logic          busy;
   logic          done;

   wm_text_reader_if #(.ADDR_WIDTH(AW), .B(B), .SHIFT_WIDTH(SW)) bus ();

   wm_text_reader #(.ADDR_WIDTH(AW), .B(B), .M(M), .SHIFT_WIDTH(SW)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .len   (len),
      .clear (clear),
      .busy  (busy),
      .done  (done),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [7:0] textMem [0:(1<<AW)-1];
   int         vectors     = 0;
   int         miscompares = 0;
   int         rdCount     = 0;
   bit         addr0Seen   = 1'b0;
   int         shiftQ [$];

   typedef struct {
      int          shift;
      int          expPos;
      logic [15:0] expData;
   } vec_t;

   vec_t vecs [3];

   // Text buffer: one-cycle synchronous read, plus fetch accounting.
   always @(posedge clk) begin
      if (bus.mem_rd_en) begin
         bus.mem_rdata <= textMem[bus.mem_addr];
         rdCount = rdCount + 1;
         if (bus.mem_addr == '0) addr0Seen = 1'b1;
      end
   end

   // Expected window: byte k of the window is text[p-k].
   function automatic logic [8*B-1:0] modelWindow(input int p);
      logic [8*B-1:0] w;
      w = '0;
      for (int k = 0; k < B; k++) w[8*k +: 8] = textMem[p-k];
      return w;
   endfunction

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Pulse start for one cycle; returns at the negedge after start is taken.
   task automatic applyStimulus(input int scanLen);
      start = 1'b1;
      len   = (AW+1)'(scanLen);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic waitValid(output int lat);
      lat = 0;
      while (!bus.win_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   // Runs one scan, checking every window against the alignment walk model.
   // Shifts come from shiftQ when it is non-empty, otherwise random.
   task automatic runScan(input int scanLen, input int holdMax);
      int p, lat, sh, hold, windows;
      rdCount       = 0;
      addr0Seen     = 1'b0;
      bus.win_ready = (holdMax == 0);
      applyStimulus(scanLen);
      p       = M - 1;
      windows = 0;
      if (scanLen < M) begin
         checkOutput("short_done", done, 1);
         checkOutput("short_busy", busy, 0);
      end
      while (p < scanLen) begin
         waitValid(lat);
         if (!bus.win_valid) begin
            checkOutput("win_timeout", 0, 1);
            return;
         end
         checkOutput("win_latency", lat, 3);
         checkOutput("win_pos", bus.win_pos, p);
         checkOutput("win_data", bus.win_data, modelWindow(p));
         hold = (holdMax > 0) ? int'($urandom_range(holdMax, 0)) : 0;
         for (int h = 0; h < hold; h++) begin
            bus.win_ready = 1'b0;
            @(negedge clk);
            checkOutput("hold_valid", bus.win_valid, 1);
            checkOutput("hold_data", bus.win_data, modelWindow(p));
            checkOutput("hold_rd_en", bus.mem_rd_en, 0);
         end
         sh = (shiftQ.size() > 0) ? shiftQ.pop_front() : int'($urandom_range(15, 0));
         bus.win_shift = SW'(sh);
         bus.win_ready = 1'b1;
         @(negedge clk);
         if (holdMax != 0) bus.win_ready = 1'b0;
         checkOutput("valid_drop", bus.win_valid, 0);
         p += (sh == 0) ? 1 : sh;
         windows++;
         checkOutput("done_pulse", done, (p >= scanLen));
      end
      @(negedge clk);
      checkOutput("end_done", done, 0);
      checkOutput("end_busy", busy, 0);
      checkOutput("end_rd_en", bus.mem_rd_en, 0);
      checkOutput("rd_count", rdCount, windows * B);
   endtask

   initial begin
      int lat;
      reset         = 1'b1;
      start         = 1'b0;
      clear         = 1'b0;
      len           = '0;
      bus.win_ready = 1'b0;
      bus.win_shift = '0;
      bus.mem_rdata = '0;
      for (int i = 0; i < (1<<AW); i++) textMem[i] = 8'h41 + 8'(i % 8);

      vecs[0] = '{shift: 2, expPos: 3, expData: 16'h4344};
      vecs[1] = '{shift: 0, expPos: 5, expData: 16'h4546};
      vecs[2] = '{shift: 3, expPos: 6, expData: 16'h4647};

      // Reset state
      #12;
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_valid", bus.win_valid, 0);
      checkOutput("rst_rd_en", bus.mem_rd_en, 0);
      checkOutput("rst_data", bus.win_data, 0);
      checkOutput("rst_pos", bus.win_pos, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // "ABCDEFGH", table-driven windows
      rdCount       = 0;
      bus.win_ready = 1'b1;
      applyStimulus(8);
      for (int i = 0; i < 3; i++) begin
         waitValid(lat);
         checkOutput("tbl_latency", lat, 3);
         checkOutput("tbl_pos", bus.win_pos, vecs[i].expPos);
         checkOutput("tbl_data", bus.win_data, vecs[i].expData);
         bus.win_shift = SW'(vecs[i].shift);
         @(negedge clk);
         checkOutput("tbl_done", done, (i == 2));
      end
      @(negedge clk);
      checkOutput("tbl_done_once", done, 0);
      checkOutput("tbl_rd_count", rdCount, 6);

      // Short text: immediate done, no fetch, no window
      rdCount = 0;
      runScan(3, 0);
      checkOutput("short_no_valid", bus.win_valid, 0);

      // Backpressure on window @3, with a stray start that must be ignored
      bus.win_ready = 1'b0;
      rdCount       = 0;
      applyStimulus(8);
      waitValid(lat);
      rdCount = 0;
      for (int h = 0; h < 5; h++) begin
         start = (h == 1);
         len   = 11'd3;
         @(negedge clk);
         checkOutput("bp_valid", bus.win_valid, 1);
         checkOutput("bp_data", bus.win_data, 16'h4344);
         checkOutput("bp_pos", bus.win_pos, 3);
      end
      start = 1'b0;
      checkOutput("bp_no_fetch", rdCount, 0);
      checkOutput("bp_no_done", done, 0);

      // Clear mid-FETCH
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      applyStimulus(8);
      checkOutput("clr_fetching", bus.mem_rd_en, 1);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      checkOutput("clr_busy", busy, 0);
      checkOutput("clr_valid", bus.win_valid, 0);
      checkOutput("clr_rd_en", bus.mem_rd_en, 0);
      checkOutput("clr_done", done, 0);
      checkOutput("clr_data", bus.win_data, 0);
      checkOutput("clr_pos", bus.win_pos, 0);
      @(negedge clk);
      checkOutput("clr_no_done", done, 0);
      shiftQ = {2, 0, 3};
      runScan(8, 0);

      // start together with clear: clear wins
      clear = 1'b1;
      applyStimulus(8);
      clear = 1'b0;
      checkOutput("clr_start_busy", busy, 0);
      checkOutput("clr_start_rd_en", bus.mem_rd_en, 0);
      @(negedge clk);

      // Async reset between edges during VALID
      bus.win_ready = 1'b0;
      applyStimulus(8);
      waitValid(lat);
      checkOutput("ar_valid_before", bus.win_valid, 1);
      #2 reset = 1'b1;
      #1;
      checkOutput("ar_valid", bus.win_valid, 0);
      checkOutput("ar_busy", busy, 0);
      checkOutput("ar_data", bus.win_data, 0);
      #1 reset = 1'b0;
      @(negedge clk);
      checkOutput("ar_idle", busy, 0);

      // Randomized scans against the model
      for (int i = 0; i < (1<<AW); i++) textMem[i] = 8'($urandom);
      for (int r = 0; r < 12; r++) runScan(int'($urandom_range(60, 0)), (r % 2) * 3);

      // Full-length text: last window at 1022, shift 15 runs past the end
      for (int i = 0; i < 67; i++) shiftQ.push_back(15);
      shiftQ.push_back(14);
      shiftQ.push_back(15);
      runScan(1 << AW, 0);
      checkOutput("full_no_addr0", addr0Seen, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
